// File: rtl/pll_reset_sequencer.sv
// PLL reset pulse, bounded lock wait with retries, lock-stable qualification of sys_rst_n, lock-loss recovery.
// Optional LOCK_LOSS_FILTER_EN: in RUN, ignore locked_s low runs shorter than GLITCH_CYCLES.
module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 50000,
  parameter int STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES    = 3,
  parameter int SYNC_STAGES    = 2,
  parameter int GLITCH_CYCLES  = 4
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       sw_reset_req,
  input  logic       locked,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       pll_ready,
  output logic       lock_fail,
  output logic [3:0] retry_cnt,
  output logic [7:0] loss_cnt
);

  localparam logic [2:0] S_PLL_RST   = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_STABLE    = 3'd2;
  localparam logic [2:0] S_RUN       = 3'd3;
  localparam logic [2:0] S_FAIL      = 3'd4;

  localparam int TMAX_A = (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES;
  localparam int TMAX   = (TMAX_A > PLL_RST_CYCLES) ? TMAX_A : PLL_RST_CYCLES;
  localparam int TW     = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TMAX - 1);

  if (PLL_RST_CYCLES < 2 || SYNC_STAGES < 2 || GLITCH_CYCLES < 1 ||
      LOCK_TIMEOUT < 1 || STABLE_CYCLES < 1 || MAX_RETRIES < 0 || MAX_RETRIES > 15) begin : g_bad_params
    $error("pll_reset_sequencer: illegal parameter set");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;
  logic [2:0]             state_q, state_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [3:0]             retry_d;
  logic [7:0]             loss_d;
  logic                   loss_det;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
  end
  assign locked_s = sync_q[SYNC_STAGES-1];

`ifdef LOCK_LOSS_FILTER_EN
  localparam int GW = (GLITCH_CYCLES > 1) ? $clog2(GLITCH_CYCLES) : 1;
  logic [GW-1:0] glitch_q;

  // Loss is declared on the GLITCH_CYCLES-th consecutive low sample.
  assign loss_det = !locked_s && (glitch_q == GW'(GLITCH_CYCLES - 1));

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n)
      glitch_q <= '0;
    else if (state_q != S_RUN || locked_s || loss_det || sw_reset_req)
      glitch_q <= '0;
    else
      glitch_q <= glitch_q + 1'b1;
  end
`else
  assign loss_det = !locked_s;
`endif

  always_comb begin
    state_d = state_q;
    timer_d = (timer_q == T_LAST) ? timer_q : timer_q + 1'b1;
    retry_d = retry_cnt;
    loss_d  = loss_cnt;
    if (sw_reset_req) begin
      state_d = S_PLL_RST;
      retry_d = '0;
    end else begin
      case (state_q)
        S_PLL_RST:
          if (timer_q == TW'(PLL_RST_CYCLES - 1)) state_d = S_WAIT_LOCK;
        S_WAIT_LOCK:
          // Lock takes precedence over a coincident timeout.
          if (locked_s) begin
            state_d = S_STABLE;
          end else if (timer_q == TW'(LOCK_TIMEOUT - 1)) begin
            if (retry_cnt == 4'(MAX_RETRIES)) begin
              state_d = S_FAIL;
            end else begin
              state_d = S_PLL_RST;
              retry_d = retry_cnt + 4'd1;
            end
          end
        S_STABLE:
          if (!locked_s)                                    state_d = S_WAIT_LOCK;
          else if (timer_q == TW'(STABLE_CYCLES - 1))       state_d = S_RUN;
        S_RUN:
          if (loss_det) begin
            state_d = S_PLL_RST;
            retry_d = '0;
            if (loss_cnt != 8'hFF) loss_d = loss_cnt + 8'd1;
          end
        S_FAIL:
          state_d = S_FAIL;
        default:
          state_d = S_PLL_RST;
      endcase
    end
    if (state_d != state_q || sw_reset_req) timer_d = '0;
  end

  // Outputs decode the next state so they change on the same edge as the state.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_PLL_RST;
      timer_q   <= '0;
      retry_cnt <= '0;
      loss_cnt  <= '0;
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      pll_ready <= 1'b0;
      lock_fail <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      retry_cnt <= retry_d;
      loss_cnt  <= loss_d;
      pll_rst   <= (state_d == S_PLL_RST) || (state_d == S_FAIL);
      sys_rst_n <= (state_d == S_RUN);
      pll_ready <= (state_d == S_RUN);
      lock_fail <= (state_d == S_FAIL);
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: directed stimulus queues expected values per cycle; a monitor compares them.
module tb_pll_reset_sequencer;

  localparam int SIG_PLL_RST   = 0;
  localparam int SIG_SYS_RST_N = 1;
  localparam int SIG_READY     = 2;
  localparam int SIG_FAIL      = 3;
  localparam int SIG_RETRY     = 4;
  localparam int SIG_LOSS      = 5;

`ifdef LOCK_LOSS_FILTER_EN
  localparam int LOW_CYC  = 4;
  localparam int LOSS_LAT = 6;
`else
  localparam int LOW_CYC  = 3;
  localparam int LOSS_LAT = 3;
`endif

  logic       refclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sw_reset_req = 1'b0;
  logic       locked = 1'b0;
  logic       pll_rst, sys_rst_n, pll_ready, lock_fail;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;

  typedef struct {
    int cyc;
    int sig;
    int val;
    int tp;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  bit   flush = 1'b0;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES(4),
    .LOCK_TIMEOUT  (64),
    .STABLE_CYCLES (16),
    .MAX_RETRIES   (2),
    .SYNC_STAGES   (2),
    .GLITCH_CYCLES (4)
  ) dut (
    .refclk      (refclk),
    .rst_n       (rst_n),
    .sw_reset_req(sw_reset_req),
    .locked      (locked),
    .pll_rst     (pll_rst),
    .sys_rst_n   (sys_rst_n),
    .pll_ready   (pll_ready),
    .lock_fail   (lock_fail),
    .retry_cnt   (retry_cnt),
    .loss_cnt    (loss_cnt)
  );

  initial forever #5 refclk = ~refclk;

  always @(posedge refclk) cyc <= cyc + 1;

  function automatic int getv(input int sig);
    case (sig)
      SIG_PLL_RST:   return int'(pll_rst);
      SIG_SYS_RST_N: return int'(sys_rst_n);
      SIG_READY:     return int'(pll_ready);
      SIG_FAIL:      return int'(lock_fail);
      SIG_RETRY:     return int'(retry_cnt);
      SIG_LOSS:      return int'(loss_cnt);
      default:       return -1;
    endcase
  endfunction

  function automatic string sig_name(input int sig);
    case (sig)
      SIG_PLL_RST:   return "pll_rst";
      SIG_SYS_RST_N: return "sys_rst_n";
      SIG_READY:     return "pll_ready";
      SIG_FAIL:      return "lock_fail";
      SIG_RETRY:     return "retry_cnt";
      SIG_LOSS:      return "loss_cnt";
      default:       return "?";
    endcase
  endfunction

  // Monitor: compares every queued expectation on the falling edge of its cycle.
  always @(negedge refclk) begin : monitor
    exp_t e;
    int   act;
    while (sb.size() > 0 && (sb[0].cyc <= cyc || flush)) begin
      e = sb.pop_front();
      compared++;
      act = getv(e.sig);
      if (e.cyc != cyc) begin
        mismatched++;
        $display("FAIL t%0d %s at cyc %0d: not sampled on time (now %0d), want %0d",
                 e.tp, sig_name(e.sig), e.cyc, cyc, e.val);
      end else if (act != e.val) begin
        mismatched++;
        $display("FAIL t%0d %s at cyc %0d: got %0d, want %0d",
                 e.tp, sig_name(e.sig), e.cyc, act, e.val);
      end
    end
  end

  task automatic expect_at(input int c, input int sig, input int val, input int tp);
    exp_t e;
    int   i;
    e.cyc = c;
    e.sig = sig;
    e.val = val;
    e.tp  = tp;
    i = 0;
    while (i < sb.size() && sb[i].cyc <= c) i++;
    sb.insert(i, e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge refclk);
  endtask

  task automatic expect_reset_vals(input int c, input int tp);
    expect_at(c, SIG_PLL_RST,   1, tp);
    expect_at(c, SIG_SYS_RST_N, 0, tp);
    expect_at(c, SIG_READY,     0, tp);
    expect_at(c, SIG_FAIL,      0, tp);
    expect_at(c, SIG_RETRY,     0, tp);
    expect_at(c, SIG_LOSS,      0, tp);
  endtask

  // Holds reset for three cycles; returns the cycle at which rst_n is released.
  task automatic do_reset(output int r);
    @(negedge refclk);
    rst_n = 1'b0;
    locked = 1'b0;
    sw_reset_req = 1'b0;
    expect_reset_vals(cyc + 1, 0);
    step(3);
    rst_n = 1'b1;
    r = cyc;
  endtask

  // Asserts rst_n between edges; outputs must already be at reset values before the next edge.
  task automatic async_reset_check(input int tp);
    @(posedge refclk);
    #2;
    rst_n = 1'b0;
    expect_reset_vals(cyc, tp);
    @(negedge refclk);
    step(2);
  endtask

  // From RUN: lock drops long enough to count, then relocks and must reach RUN again.
  task automatic loss_event(input int n, input int tp);
    int d, l;
    d = cyc;
    l = d + LOSS_LAT;
    expect_at(l - 1,  SIG_SYS_RST_N, 1, tp);
    expect_at(l,      SIG_SYS_RST_N, 0, tp);
    expect_at(l,      SIG_READY,     0, tp);
    expect_at(l,      SIG_PLL_RST,   1, tp);
    expect_at(l,      SIG_LOSS,      n, tp);
    expect_at(l,      SIG_RETRY,     0, tp);
    expect_at(l + 20, SIG_SYS_RST_N, 0, tp);
    expect_at(l + 21, SIG_SYS_RST_N, 1, tp);
    locked = 1'b0;
    step(LOW_CYC);
    locked = 1'b1;
    step(30);
  endtask

  initial begin : stim
    int r, d, l, f;

    // 1: clean bring-up, lock 10 cycles after pll_rst falls
    do_reset(r);
    expect_at(r + 3,  SIG_PLL_RST,   1, 1);
    expect_at(r + 4,  SIG_PLL_RST,   0, 1);
    expect_at(r + 32, SIG_SYS_RST_N, 0, 1);
    expect_at(r + 33, SIG_SYS_RST_N, 1, 1);
    expect_at(r + 32, SIG_READY,     0, 1);
    expect_at(r + 33, SIG_READY,     1, 1);
    expect_at(r + 33, SIG_RETRY,     0, 1);
    step(14);
    locked = 1'b1;
    step(26);

    // 4: loss of lock in RUN
`ifdef LOCK_LOSS_FILTER_EN
    d = cyc;
    expect_at(d + 8, SIG_SYS_RST_N, 1, 4);
    expect_at(d + 8, SIG_READY,     1, 4);
    expect_at(d + 8, SIG_LOSS,      0, 4);
    locked = 1'b0;
    step(3);
    locked = 1'b1;
    step(12);
`endif
    loss_event(1, 4);

    // 2b: permanent loss from RUN runs out of retries into FAIL
    d = cyc;
    l = d + LOSS_LAT;
    expect_at(l,       SIG_LOSS,      2, 2);
    expect_at(l + 67,  SIG_PLL_RST,   0, 2);
    expect_at(l + 68,  SIG_PLL_RST,   1, 2);
    expect_at(l + 68,  SIG_RETRY,     1, 2);
    expect_at(l + 136, SIG_RETRY,     2, 2);
    expect_at(l + 203, SIG_FAIL,      0, 2);
    expect_at(l + 204, SIG_FAIL,      1, 2);
    expect_at(l + 204, SIG_PLL_RST,   1, 2);
    expect_at(l + 204, SIG_SYS_RST_N, 0, 2);
    expect_at(l + 204, SIG_RETRY,     2, 2);
    locked = 1'b0;
    step(LOSS_LAT + 215);

    // 5: software restart out of FAIL with lock present
    f = cyc;
    expect_at(f + 1,  SIG_FAIL,      0, 5);
    expect_at(f + 1,  SIG_RETRY,     0, 5);
    expect_at(f + 1,  SIG_PLL_RST,   1, 5);
    expect_at(f + 1,  SIG_LOSS,      2, 5);
    expect_at(f + 4,  SIG_PLL_RST,   1, 5);
    expect_at(f + 5,  SIG_PLL_RST,   0, 5);
    expect_at(f + 21, SIG_SYS_RST_N, 0, 5);
    expect_at(f + 22, SIG_SYS_RST_N, 1, 5);
    expect_at(f + 22, SIG_READY,     1, 5);
    expect_at(f + 22, SIG_LOSS,      2, 5);
    sw_reset_req = 1'b1;
    locked = 1'b1;
    step(1);
    sw_reset_req = 1'b0;
    step(30);

    // 6a: build loss_cnt up to 5, then async reset in RUN
    loss_event(3, 6);
    loss_event(4, 6);
    loss_event(5, 6);
    async_reset_check(6);

    // 3: one-cycle lock drop at STABLE timer=8 restarts the stable window
    do_reset(r);
    expect_at(r + 33, SIG_SYS_RST_N, 0, 3);
    expect_at(r + 42, SIG_SYS_RST_N, 0, 3);
    expect_at(r + 43, SIG_SYS_RST_N, 1, 3);
    expect_at(r + 43, SIG_READY,     1, 3);
    expect_at(r + 43, SIG_RETRY,     0, 3);
    step(14);
    locked = 1'b1;
    step(9);
    locked = 1'b0;
    step(1);
    locked = 1'b1;
    step(25);

    // 6b: async reset mid-STABLE
    do_reset(r);
    expect_at(r + 24, SIG_PLL_RST, 0, 6);
    step(14);
    locked = 1'b1;
    step(10);
    async_reset_check(6);

    // 2: no lock at all after reset
    do_reset(r);
    expect_at(r + 67,  SIG_PLL_RST,   0, 2);
    expect_at(r + 68,  SIG_PLL_RST,   1, 2);
    expect_at(r + 68,  SIG_RETRY,     1, 2);
    expect_at(r + 136, SIG_PLL_RST,   1, 2);
    expect_at(r + 136, SIG_RETRY,     2, 2);
    expect_at(r + 203, SIG_FAIL,      0, 2);
    expect_at(r + 204, SIG_FAIL,      1, 2);
    expect_at(r + 204, SIG_PLL_RST,   1, 2);
    expect_at(r + 250, SIG_PLL_RST,   1, 2);
    expect_at(r + 250, SIG_FAIL,      1, 2);
    expect_at(r + 250, SIG_SYS_RST_N, 0, 2);
    step(260);

    step(5);
    @(posedge refclk);
    flush = 1'b1;
    @(negedge refclk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Sits directly upstream of the system PLL wrapper, in the refclk (50 MHz) domain.
- Drives the PLL reset input and monitors the PLL `locked` output.
- Releases the system reset only after lock has stayed stable for a set time.
- On lock timeout it retries the PLL reset a limited number of times, then parks in a fail state; on loss of lock while running it re-asserts the system reset and restarts the PLL.

Parameters:
- PLL_RST_CYCLES, 16: width of the pll_rst pulse, in refclk cycles (≥2).
- LOCK_TIMEOUT, 50000: cycles to wait for lock after pll_rst release (1 ms).
- STABLE_CYCLES, 1024: cycles locked must stay high before system reset release.
- MAX_RETRIES, 3: PLL reset retries after the initial attempt before FAIL.
- SYNC_STAGES, 2: synchroniser depth for `locked` (≥2).
- GLITCH_CYCLES, 4: loss-of-lock filter length; used only with LOCK_LOSS_FILTER_EN.

Ports:
- refclk, input, 1: sole clock.
- rst_n, input, 1: asynchronous active-low reset.
- sw_reset_req, input, 1: synchronous single-cycle request to restart the sequence.
- locked, input, 1: PLL lock, asynchronous; synchronised internally.
- pll_rst, output, 1: active-high reset to the PLL.
- sys_rst_n, output, 1: active-low system reset for downstream logic; consumers resynchronise it.
- pll_ready, output, 1: high while in RUN.
- lock_fail, output, 1: high while in FAIL.
- retry_cnt, output, 4: retries used in the current attempt.
- loss_cnt, output, 8: count of lock losses in RUN; saturates at 255.

Behaviour:
- Reset values (rst_n low): state PLL_RST, pll_rst=1, sys_rst_n=0, pll_ready=0, lock_fail=0, retry_cnt=0, loss_cnt=0, timer=0, synchroniser cleared.
- Outputs are registered and take effect on the same edge as the state they belong to.
- locked_s is `locked` after SYNC_STAGES flops.
- PLL_RST:
  - pll_rst=1; timer counts 0..PLL_RST_CYCLES-1.
  - At terminal count: go to WAIT_LOCK with timer=0; pll_rst=0 from that edge.
- WAIT_LOCK:
  - locked_s=1: go to STABLE with timer=0.
  - Else, at timer==LOCK_TIMEOUT-1: if retry_cnt==MAX_RETRIES go to FAIL; otherwise retry_cnt+1 and go to PLL_RST.
  - If locked_s rises in the same cycle as the timeout, lock wins.
- STABLE:
  - locked_s=0: go to WAIT_LOCK with timer=0; retry_cnt unchanged; no timeout penalty.
  - At timer==STABLE_CYCLES-1 with locked_s=1: go to RUN.
  - sys_rst_n rises exactly STABLE_CYCLES+1 cycles after the first cycle locked_s is sampled high in WAIT_LOCK.
- RUN:
  - sys_rst_n=1, pll_ready=1.
  - locked_s=0: loss_cnt+1 (saturating), retry_cnt=0, go to PLL_RST; sys_rst_n=0 and pll_ready=0 on that edge.
- FAIL:
  - pll_rst=1, sys_rst_n=0, lock_fail=1.
  - Leaves only via sw_reset_req or rst_n.
- sw_reset_req has highest priority in every state: go to PLL_RST, timer=0, retry_cnt=0, lock_fail=0, sys_rst_n=0; loss_cnt is kept.
- The timer is sized to max(LOCK_TIMEOUT, STABLE_CYCLES, PLL_RST_CYCLES) and never wraps; it clears on every state change.
- rst_n asserted mid-sequence returns all registers to reset values immediately (asynchronous).

Optional Feature:
- Macro: LOCK_LOSS_FILTER_EN.
- Defined: in RUN, loss is declared only after locked_s has been low for GLITCH_CYCLES consecutive cycles. A low run shorter than that is ignored: no state change, loss_cnt unchanged, and the filter counter clears when locked_s returns high. Added latency from locked_s falling to sys_rst_n falling is GLITCH_CYCLES-1 cycles.
- Undefined: a single low cycle of locked_s in RUN triggers loss. STABLE and WAIT_LOCK behave identically in both builds.

Test Plan:
Bench parameters: PLL_RST_CYCLES=4, LOCK_TIMEOUT=64, STABLE_CYCLES=16, MAX_RETRIES=2, SYNC_STAGES=2.
1. Release rst_n; raise locked 10 cycles after pll_rst falls → pll_rst high 4 cycles; sys_rst_n rises 17 cycles after locked_s is first high; pll_ready=1; retry_cnt=0.
2. Hold locked=0 → 3 pll_rst pulses (retry_cnt 0,1,2); FAIL entered 3×(4+64) cycles after reset; lock_fail=1; pll_rst stays 1.
3. In STABLE, drop locked for 1 cycle at timer=8 → return to WAIT_LOCK; sys_rst_n stays 0; relock gives a full 16-cycle stable window; retry_cnt unchanged.
4. In RUN, drop locked for 3 cycles → loss_cnt=1, sys_rst_n=0, PLL_RST re-entered, relock reaches RUN. With LOCK_LOSS_FILTER_EN: no reaction to 3 cycles low; 4 cycles low gives loss_cnt=1.
5. In FAIL, pulse sw_reset_req → lock_fail=0, pll_rst pulse, retry_cnt=0, loss_cnt kept; with locked=1 the block reaches RUN.
6. Assert rst_n low mid-STABLE and mid-RUN with loss_cnt=5 → all outputs at reset values within the same cycle; loss_cnt=0.
